// File: rtl/lcd_timing.sv
// LCD timing generator: dot/line counters, STAT mode, coincidence, renderer strobes and interrupts.
// Define LCD_TIMING_STAT_IRQ_EN to build the STAT interrupt logic; otherwise stat_irq is tied low.
module lcd_timing #(
    parameter int DOTS_PER_LINE = 456,
    parameter int TOTAL_LINES   = 154,
    parameter int VISIBLE_LINES = 144,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       drawline,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       renderer_reset
);
    localparam int DW = $clog2(DOTS_PER_LINE);
    localparam logic [DW-1:0] DOT_LAST  = DW'(DOTS_PER_LINE - 1);
    localparam logic [DW-1:0] OAM_END   = DW'(OAM_DOTS);
    localparam logic [DW-1:0] XFER_END  = DW'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]    LINE_LAST = 8'(TOTAL_LINES - 1);
    localparam logic [7:0]    VIS_LINES = 8'(VISIBLE_LINES);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    logic [DW-1:0] dot_r, dot_nxt_s;
    logic [7:0]    line_r, line_nxt_s;
    mode_t         mode_r, mode_nxt_s;
    logic          coincidence_r, coin_nxt_s;
    logic          drawline_r;
    logic          vblank_irq_r, vblank_nxt_s;
    logic          renderer_reset_r;

    function automatic mode_t mode_of(input logic [DW-1:0] d, input logic [7:0] l);
        mode_t m;
        if (l >= VIS_LINES) begin
            m = MODE_VBLANK;
        end else if (d < OAM_END) begin
            m = MODE_OAM;
        end else if (d < XFER_END) begin
            m = MODE_XFER;
        end else begin
            m = MODE_HBLANK;
        end
        return m;
    endfunction

    // Next dot/line state; every registered output is derived from it so they never skew.
    // The first enabled cycle after the display was off restarts at line 0, dot 0.
    always_comb begin
        dot_nxt_s    = '0;
        line_nxt_s   = 8'd0;
        mode_nxt_s   = MODE_HBLANK;
        if (!lcd_enable || renderer_reset_r) begin
            dot_nxt_s  = '0;
            line_nxt_s = 8'd0;
        end else if (dot_r == DOT_LAST) begin
            dot_nxt_s  = '0;
            line_nxt_s = (line_r == LINE_LAST) ? 8'd0 : line_r + 8'd1;
        end else begin
            dot_nxt_s  = dot_r + DW'(1);
            line_nxt_s = line_r;
        end
        if (lcd_enable) begin
            mode_nxt_s = mode_of(dot_nxt_s, line_nxt_s);
        end else begin
            mode_nxt_s = MODE_HBLANK;
        end
        coin_nxt_s   = (line_nxt_s == lyc);
        vblank_nxt_s = lcd_enable && (line_nxt_s == VIS_LINES) && (dot_nxt_s == '0);
    end

    // Counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dot_r            <= '0;
            line_r           <= 8'd0;
            mode_r           <= MODE_HBLANK;
            coincidence_r    <= 1'b0;
            drawline_r       <= 1'b0;
            vblank_irq_r     <= 1'b0;
            renderer_reset_r <= 1'b1;
        end else begin
            dot_r            <= dot_nxt_s;
            line_r           <= line_nxt_s;
            mode_r           <= mode_nxt_s;
            coincidence_r    <= coin_nxt_s;
            drawline_r       <= (mode_nxt_s == MODE_XFER);
            vblank_irq_r     <= vblank_nxt_s;
            renderer_reset_r <= !lcd_enable;
        end
    end

`ifdef LCD_TIMING_STAT_IRQ_EN
    logic stat_line_s, stat_line_r, stat_irq_r;

    // STAT line is the OR of the enabled sources; held low while the display is off.
    always_comb begin
        stat_line_s = 1'b0;
        if (lcd_enable) begin
            stat_line_s = ((mode_nxt_s == MODE_HBLANK) && stat_int_en[0]) ||
                          ((mode_nxt_s == MODE_VBLANK) && stat_int_en[1]) ||
                          ((mode_nxt_s == MODE_OAM)    && stat_int_en[2]) ||
                          (coin_nxt_s                  && stat_int_en[3]);
        end else begin
            stat_line_s = 1'b0;
        end
    end

    // Interrupt fires only on a rising edge of the STAT line, so overlapping sources merge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_line_r <= 1'b0;
            stat_irq_r  <= 1'b0;
        end else begin
            stat_line_r <= stat_line_s;
            stat_irq_r  <= stat_line_s && !stat_line_r;
        end
    end

    assign stat_irq = stat_irq_r;
`else
    logic unused_stat_en_s;
    assign unused_stat_en_s = ^stat_int_en;
    assign stat_irq         = 1'b0;
`endif

    assign ly             = line_r;
    assign mode           = mode_r;
    assign coincidence    = coincidence_r;
    assign drawline       = drawline_r;
    assign vblank_irq     = vblank_irq_r;
    assign renderer_reset = renderer_reset_r;
endmodule
